// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable, run enable and
// a fetch-latency delay line that aligns framebuffer data with sync and valid.
module vga_timing_gen #(
    parameter int CW        = 10,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int FETCH_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [23:0]   vga_data,
    output logic [CW-1:0] h_addr,
    output logic [CW-1:0] v_addr,
    output logic          fetch,
    output logic          pix_ce,
    output logic          frame_start,
    output logic          line_start,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] CW_ONE   = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ORG    = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] V_ORG    = CW'(V_SYNC + V_BACK);

    // Region bounds are one bit wider so an active end equal to 2^CW still compares correctly.
    localparam logic [CW:0] HS_END = (CW+1)'(H_SYNC);
    localparam logic [CW:0] HA_LO  = (CW+1)'(H_SYNC + H_BACK);
    localparam logic [CW:0] HA_HI  = (CW+1)'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CW:0] VS_END = (CW+1)'(V_SYNC);
    localparam logic [CW:0] VA_LO  = (CW+1)'(V_SYNC + V_BACK);
    localparam logic [CW:0] VA_HI  = (CW+1)'(V_SYNC + V_BACK + V_ACTIVE);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } flags_t;

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          tick;
    logic          hs0, vs0, act0;
    flags_t        s0, last;
    flags_t        out_q, out_d;
    logic [23:0]   rgb_q, rgb_d;

    assign tick = en & ~rst & (div_q == DIV_LAST);

    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        if (!en) begin
            div_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
            if (tick) begin
                if (x_q == H_LAST) begin
                    x_d = '0;
                    y_d = (y_q == V_LAST) ? '0 : y_q + CW_ONE;
                end else begin
                    x_d = x_q + CW_ONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    always_comb begin
        hs0  = ({1'b0, x_q} < HS_END);
        vs0  = ({1'b0, y_q} < VS_END);
        act0 = ({1'b0, x_q} >= HA_LO) && ({1'b0, x_q} < HA_HI) &&
               ({1'b0, y_q} >= VA_LO) && ({1'b0, y_q} < VA_HI);
    end

    assign s0          = {hs0, vs0, act0};
    assign fetch       = act0 & en & ~rst;
    assign h_addr      = act0 ? (x_q - H_ORG) : '0;
    assign v_addr      = act0 ? (y_q - V_ORG) : '0;
    assign pix_ce      = tick;
    assign line_start  = tick & (x_q == '0);
    assign frame_start = tick & (x_q == '0) & (y_q == '0);

    generate
        if (FETCH_LAT == 0) begin : g_no_pipe
            assign last = s0;
        end else begin : g_pipe
            flags_t pipe_q [FETCH_LAT];
            flags_t pipe_d [FETCH_LAT];

            always_comb begin
                pipe_d = pipe_q;
                if (!en) begin
                    for (int i = 0; i < FETCH_LAT; i++) pipe_d[i] = '0;
                end else if (tick) begin
                    pipe_d[0] = s0;
                    for (int i = 1; i < FETCH_LAT; i++) pipe_d[i] = pipe_q[i-1];
                end
            end

            // NOTE: the delay line is a few flops rather than a RAM, so it is reset like any other state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < FETCH_LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign last = pipe_q[FETCH_LAT-1];
        end
    endgenerate

    always_comb begin
        out_d = out_q;
        rgb_d = rgb_q;
        if (!en) begin
            out_d = '0;
            rgb_d = '0;
        end else if (tick) begin
            out_d = last;
            rgb_d = last.act ? vga_data : 24'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            rgb_q <= '0;
        end else begin
            out_q <= out_d;
            rgb_q <= rgb_d;
        end
    end

    assign hsync = out_q.hs ? HS_POL : ~HS_POL;
    assign vsync = out_q.vs ? VS_POL : ~VS_POL;
    assign valid = out_q.act;
    assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a tiny raster (A), a divided default-width raster with
// 2-tick fetch latency (B) and the default 640x480 configuration (C) share one clock.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b, en_c;
    logic [23:0] data_a;
    logic [23:0] data_b = '0;
    logic [23:0] b_r1 = '0;
    logic [23:0] data_c = '0;

    logic [9:0] ha_a, va_a, ha_b, va_b, ha_c, va_c;
    logic fe_a, ce_a, fs_a, ls_a, hs_a, vs_a, vd_a;
    logic fe_b, ce_b, fs_b, ls_b, hs_b, vs_b, vd_b;
    logic fe_c, ce_c, fs_c, ls_c, hs_c, vs_c, vd_c;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .FETCH_LAT(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .vga_data(data_a),
        .h_addr(ha_a), .v_addr(va_a), .fetch(fe_a), .pix_ce(ce_a),
        .frame_start(fs_a), .line_start(ls_a), .hsync(hs_a), .vsync(vs_a),
        .valid(vd_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_timing_gen #(
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(3), .V_FRONT(1),
        .CLK_DIV(3), .FETCH_LAT(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .vga_data(data_b),
        .h_addr(ha_b), .v_addr(va_b), .fetch(fe_b), .pix_ce(ce_b),
        .frame_start(fs_b), .line_start(ls_b), .hsync(hs_b), .vsync(vs_b),
        .valid(vd_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    vga_timing_gen u_dut_c (
        .clk(clk), .rst(rst), .en(en_c), .vga_data(data_c),
        .h_addr(ha_c), .v_addr(va_c), .fetch(fe_c), .pix_ce(ce_c),
        .frame_start(fs_c), .line_start(ls_c), .hsync(hs_c), .vsync(vs_c),
        .valid(vd_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c)
    );

    // Framebuffer models: combinational (A), 2-tick (B) and 1-tick (C) synchronous RAMs.
    assign data_a = {va_a[7:0], ha_a[7:0], 8'h5A};

    always @(posedge clk) begin
        if (ce_b) begin
            b_r1   <= {va_b[7:0], ha_b[7:0], 8'h5A};
            data_b <= b_r1;
        end
    end

    always @(posedge clk) begin
        if (ce_c) data_c <= {va_c[7:0], ha_c[7:0], 8'h5A};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int x0, y0, x1, y1, act0, e_hs, e_vs, e_vd, e_rgb;
    int a_hs_hi, a_vs_hi;
    int b_hs_lo, b_ls1, b_ls2, fvb, b_rgb0, b_rgb2, b_rgb3, b_vs_lo_s, b_vs_hi_s, hold_viol;
    int c_hs_lo, c_ls1, c_ls2, fvc, c_rgb0, c_rgb1, c_rgb639, c_vd640, c_rgb800, c_vcnt;
    int c_vs_1601, c_vs_1602, zviol, found, fs_at;
    logic [26:0] prev_b;
    logic        prev_ce_b;

    initial begin
        rst  = 1'b1;
        en_a = 1'b1;
        en_b = 1'b1;
        en_c = 1'b1;
        #12;

        // Reset state while en is already high.
        chk("rst_a_hsync", 32'(hs_a), 0);
        chk("rst_a_vsync", 32'(vs_a), 0);
        chk("rst_a_pix_ce", 32'(ce_a), 0);
        chk("rst_a_frame_start", 32'(fs_a), 0);
        chk("rst_a_line_start", 32'(ls_a), 0);
        chk("rst_c_hsync", 32'(hs_c), 1);
        chk("rst_c_vsync", 32'(vs_c), 1);
        chk("rst_c_valid", 32'(vd_c), 0);
        chk("rst_c_rgb", 32'({r_c, g_c, b_c}), 0);
        chk("rst_c_fetch", 32'(fe_c), 0);
        chk("rst_b_pix_ce", 32'(ce_b), 0);

        a_hs_hi = 0; a_vs_hi = 0;
        b_hs_lo = 0; b_ls1 = -1; b_ls2 = -1; fvb = -1; hold_viol = 0;
        b_rgb0 = -1; b_rgb2 = -1; b_rgb3 = -1; b_vs_lo_s = -1; b_vs_hi_s = -1;
        c_hs_lo = 0; c_ls1 = -1; c_ls2 = -1; fvc = -1; c_vcnt = 0;
        c_rgb0 = -1; c_rgb1 = -1; c_rgb639 = -1; c_vd640 = -1; c_rgb800 = -1;
        c_vs_1601 = -1; c_vs_1602 = -1; zviol = 0;
        prev_b = '0; prev_ce_b = 1'b0;

        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int k = 0; k < 29000; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end

            // A: stage 0 shows position k, outputs show position k-1.
            if (k <= 48) begin
                x0 = k % 8;
                y0 = (k / 8) % 6;
                act0 = (x0 >= 3 && x0 < 7 && y0 >= 2 && y0 < 5) ? 1 : 0;
                chk("a_pix_ce", 32'(ce_a), 1);
                chk("a_fetch", 32'(fe_a), act0);
                chk("a_h_addr", 32'(ha_a), (act0 != 0) ? x0 - 3 : 0);
                chk("a_v_addr", 32'(va_a), (act0 != 0) ? y0 - 2 : 0);
                chk("a_frame_start", 32'(fs_a), (x0 == 0 && y0 == 0) ? 1 : 0);
                chk("a_line_start", 32'(ls_a), (x0 == 0) ? 1 : 0);
                if (k == 0) begin
                    e_hs = 0; e_vs = 0; e_vd = 0; e_rgb = 0;
                end else begin
                    x1 = (k - 1) % 8;
                    y1 = ((k - 1) / 8) % 6;
                    e_hs = (x1 < 2) ? 1 : 0;
                    e_vs = (y1 < 1) ? 1 : 0;
                    e_vd = (x1 >= 3 && x1 < 7 && y1 >= 2 && y1 < 5) ? 1 : 0;
                    e_rgb = (e_vd != 0) ? (((y1 - 2) << 16) | ((x1 - 3) << 8) | 'h5A) : 0;
                end
                chk("a_hsync", 32'(hs_a), e_hs);
                chk("a_vsync", 32'(vs_a), e_vs);
                chk("a_valid", 32'(vd_a), e_vd);
                chk("a_rgb", 32'({r_a, g_a, b_a}), e_rgb);
                if (k < 48) begin
                    a_hs_hi += int'(hs_a);
                    a_vs_hi += int'(vs_a);
                end
            end

            // B: one tick every third clk, outputs three ticks behind stage 0.
            if (k < 12) chk("b_pix_ce_pattern", 32'(ce_b), (k % 3 == 2) ? 1 : 0);
            if (k < 2400 && !hs_b) b_hs_lo++;
            if (ls_b) begin
                if (b_ls1 < 0) b_ls1 = k;
                else if (b_ls2 < 0) b_ls2 = k;
            end
            if (fvb < 0 && vd_b) fvb = k;
            if (fvb >= 0 && k == fvb) b_rgb0 = int'({r_b, g_b, b_b});
            if (fvb >= 0 && k == fvb + 2) b_rgb2 = int'({r_b, g_b, b_b});
            if (fvb >= 0 && k == fvb + 3) b_rgb3 = int'({r_b, g_b, b_b});
            if (k == 2408) b_vs_lo_s = int'(vs_b);
            if (k == 2409) b_vs_hi_s = int'(vs_b);
            if (k > 0 && !prev_ce_b && prev_b != {vd_b, hs_b, vs_b, r_b, g_b, b_b}) hold_viol++;
            prev_b = {vd_b, hs_b, vs_b, r_b, g_b, b_b};
            prev_ce_b = ce_b;

            // C: default raster, outputs two ticks behind stage 0.
            if (k == 0) chk("c_frame_start_first", 32'(fs_c), 1);
            if (k < 800 && !hs_c) c_hs_lo++;
            if (ls_c) begin
                if (c_ls1 < 0) c_ls1 = k;
                else if (c_ls2 < 0) c_ls2 = k;
            end
            if (k == 1601) c_vs_1601 = int'(vs_c);
            if (k == 1602) c_vs_1602 = int'(vs_c);
            if (fvc < 0 && vd_c) fvc = k;
            if (fvc >= 0 && k == fvc) c_rgb0 = int'({r_c, g_c, b_c});
            if (fvc >= 0 && k == fvc + 1) c_rgb1 = int'({r_c, g_c, b_c});
            if (fvc >= 0 && k == fvc + 639) c_rgb639 = int'({r_c, g_c, b_c});
            if (fvc >= 0 && k == fvc + 640) c_vd640 = int'(vd_c);
            if (fvc >= 0 && k == fvc + 800) c_rgb800 = int'({r_c, g_c, b_c});
            if (fvc >= 0 && k < fvc + 800 && vd_c) c_vcnt++;

            if (!vd_a && {r_a, g_a, b_a} != 24'h0) zviol++;
            if (!vd_b && {r_b, g_b, b_b} != 24'h0) zviol++;
            if (!vd_c && {r_c, g_c, b_c} != 24'h0) zviol++;
        end

        chk("a_hsync_high_per_frame", a_hs_hi, 12);
        chk("a_vsync_high_per_frame", a_vs_hi, 8);
        chk("b_first_valid_clk", fvb, 7641);
        chk("b_rgb_first", b_rgb0, 'h00005A);
        chk("b_rgb_hold", b_rgb2, 'h00005A);
        chk("b_rgb_next", b_rgb3, 'h00015A);
        chk("b_hsync_low_clks", b_hs_lo, 288);
        chk("b_line_start_1", b_ls1, 2);
        chk("b_line_start_2", b_ls2, 2402);
        chk("b_vsync_last_sync", b_vs_lo_s, 0);
        chk("b_vsync_after_sync", b_vs_hi_s, 1);
        chk("b_change_off_tick", hold_viol, 0);
        chk("c_first_valid_clk", fvc, 28146);
        chk("c_rgb_first", c_rgb0, 'h00005A);
        chk("c_rgb_second", c_rgb1, 'h00015A);
        chk("c_rgb_last_of_line", c_rgb639, 'h007F5A);
        chk("c_valid_after_line", c_vd640, 0);
        chk("c_rgb_next_row", c_rgb800, 'h01005A);
        chk("c_valid_per_line", c_vcnt, 640);
        chk("c_hsync_low_ticks", c_hs_lo, 96);
        chk("c_line_start_1", c_ls1, 0);
        chk("c_line_start_2", c_ls2, 800);
        chk("c_vsync_last_sync", c_vs_1601, 0);
        chk("c_vsync_after_sync", c_vs_1602, 1);
        chk("rgb_zero_when_invalid", zviol, 0);

        // Run-enable drop at stage-0 (300,40) of C.
        found = 0;
        for (int k = 0; k < 5000 && found == 0; k++) begin
            @(negedge clk);
            #1;
            if (fe_c && ha_c == 10'd156 && va_c == 10'd5) found = 1;
        end
        chk("c_en_drop_reached", found, 1);
        chk("c_valid_before_drop", 32'(vd_c), 1);
        chk("c_rgb_before_drop", 32'({r_c, g_c, b_c}), 'h059A5A);
        en_b = 1'b0;
        en_c = 1'b0;
        #1;
        chk("c_pix_ce_en_low", 32'(ce_c), 0);
        chk("c_fetch_en_low", 32'(fe_c), 0);
        @(negedge clk);
        #1;
        chk("c_idle_valid", 32'(vd_c), 0);
        chk("c_idle_rgb", 32'({r_c, g_c, b_c}), 0);
        chk("c_idle_hsync", 32'(hs_c), 1);
        chk("c_idle_vsync", 32'(vs_c), 1);
        chk("c_idle_h_addr", 32'(ha_c), 0);
        chk("b_idle_hsync", 32'(hs_b), 1);
        repeat (4) @(negedge clk);
        #1;
        en_b = 1'b1;
        en_c = 1'b1;
        #1;
        chk("c_restart_pix_ce", 32'(ce_c), 1);
        chk("c_restart_frame_start", 32'(fs_c), 1);
        chk("c_restart_line_start", 32'(ls_c), 1);
        chk("b_restart_pix_ce_0", 32'(ce_b), 0);
        @(negedge clk);
        #1;
        chk("b_restart_pix_ce_1", 32'(ce_b), 0);
        @(negedge clk);
        #1;
        chk("b_restart_pix_ce_2", 32'(ce_b), 1);
        chk("b_restart_frame_start", 32'(fs_b), 1);

        // Asynchronous reset in the middle of an active line of A.
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            #1;
            if (vd_a) found = 1;
        end
        chk("a_active_reached", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_a_valid", 32'(vd_a), 0);
        chk("arst_a_rgb", 32'({r_a, g_a, b_a}), 0);
        chk("arst_a_hsync", 32'(hs_a), 0);
        chk("arst_a_vsync", 32'(vs_a), 0);
        chk("arst_a_pix_ce", 32'(ce_a), 0);
        chk("arst_a_fetch", 32'(fe_a), 0);
        chk("arst_c_hsync", 32'(hs_c), 1);
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_release_frame_start", 32'(fs_a), 1);
        chk("arst_release_line_start", 32'(ls_a), 1);
        fs_at = -1;
        for (int j = 1; j <= 48; j++) begin
            @(negedge clk);
            #1;
            if (j == 8) chk("arst_line_start_x0", 32'(ls_a), 1);
            if (fs_at < 0 && fs_a) fs_at = j;
        end
        chk("arst_next_frame_start", fs_at, 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
